alu_muldiv_seq: RTL

- Multi-cycle sequencer that performs 16x16 unsigned multiply (shift-add) and 16/16 unsigned divide (restoring) by driving a shared single-cycle ALU instance through its operand/control pins.
- Sits beside the execute stage. It owns the ALU pins only while busy; the mux to the ALU is outside this block.
- Start/busy/done handshake; results are held in registers until the next accepted start.

---
 rtl/alu_muldiv_seq_pkg.sv | 30 +++
 rtl/alu_muldiv_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_seq_pkg
//  Description : Shared types and constants for the multi-cycle mul/div
//                sequencer that drives an external single-cycle ALU.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_muldiv_seq_pkg;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // ALU opcode for the arithmetic add path (Op[2]=0 selects arithmetic)
    localparam logic [2:0] OP_ADD = 3'b000;

    // Operation select sampled with start
    localparam logic MD_MUL = 1'b0;
    localparam logic MD_DIV = 1'b1;

    // Iteration count equals the operand width
    localparam int         NITER    = 16;
    localparam logic [3:0] CNT_LAST = 4'(NITER - 1);

endpackage : alu_muldiv_seq_pkg
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_seq
//  Description : 16x16 unsigned shift-add multiply and 16/16 unsigned
//                restoring divide, one iteration per clock, borrowing an
//                external single-cycle ALU through its operand/control pins.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        op_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        dz_o,
    output logic [15:0] result_hi_o,
    output logic [15:0] result_lo_o,
    output logic [15:0] alu_A_o,
    output logic [15:0] alu_B_o,
    output logic [2:0]  alu_Op_o,
    output logic        alu_Cin_o,
    output logic        alu_invA_o,
    output logic        alu_invB_o,
    output logic        alu_sign_o,
    input  logic [15:0] alu_Out_i,
    input  logic        alu_Ofl_i
);

    state_t      state_q;
    logic [15:0] acc_q;      // product high half (MUL) / partial remainder (DIV)
    logic [15:0] lo_q;       // multiplier shifting into product low half / quotient
    logic [15:0] opnd_q;     // multiplicand (MUL) / divisor (DIV)
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        dz_q;
    logic [15:0] res_hi_q;
    logic [15:0] res_lo_q;

    logic [15:0] acc_d;
    logic [15:0] lo_d;
    logic [15:0] div_sh;
    logic        div_take;

    // ALU pin drive and next value of the working registers for this iteration
    always_comb begin
        alu_A_o    = 16'h0000;
        alu_B_o    = 16'h0000;
        alu_Cin_o  = 1'b0;
        alu_invB_o = 1'b0;
        acc_d      = acc_q;
        lo_d       = lo_q;
        div_sh     = {acc_q[14:0], lo_q[15]};
        div_take   = 1'b0;
        case (state_q)
            MUL: begin
                alu_A_o = acc_q;
                alu_B_o = opnd_q;
                // Conditional add of the multiplicand, then shift the 33-bit
                // {carry, hi, lo} right by one; the carry lands in hi[15].
                if (lo_q[0]) begin
                    {acc_d, lo_d} = {alu_Ofl_i, alu_Out_i, lo_q[15:1]};
                end else begin
                    {acc_d, lo_d} = {1'b0, acc_q, lo_q[15:1]};
                end
            end
            DIV: begin
                // A + ~B + 1 = A - B; carry-out set means no borrow.
                alu_A_o    = div_sh;
                alu_B_o    = opnd_q;
                alu_invB_o = 1'b1;
                alu_Cin_o  = 1'b1;
                // A shifted-out remainder MSB means the 17-bit value exceeds
                // any 16-bit divisor, so subtraction always succeeds.
                div_take   = alu_Ofl_i | acc_q[15];
                acc_d      = div_take ? alu_Out_i : div_sh;
                lo_d       = {lo_q[14:0], div_take};
            end
            default: ;
        endcase
    end

    // Sequencer FSM with registered handshake outputs and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= 16'h0000;
            lo_q     <= 16'h0000;
            opnd_q   <= 16'h0000;
            cnt_q    <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            res_hi_q <= 16'h0000;
            res_lo_q <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        cnt_q <= 4'd0;
                        acc_q <= 16'h0000;
                        if (op_i == MD_MUL) begin
                            opnd_q  <= a_i;
                            lo_q    <= b_i;
                            busy_q  <= 1'b1;
                            state_q <= MUL;
                        end else if (b_i != 16'h0000) begin
                            opnd_q  <= b_i;
                            lo_q    <= a_i;
                            busy_q  <= 1'b1;
                            state_q <= DIV;
                        end else begin
                            // Divide by zero: all-ones quotient, dividend as remainder
                            res_hi_q <= a_i;
                            res_lo_q <= 16'hFFFF;
                            dz_q     <= 1'b1;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end
                    end
                end
                MUL, DIV: begin
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        res_hi_q <= acc_d;
                        res_lo_q <= lo_d;
                        dz_q     <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign dz_o        = dz_q;
    assign result_hi_o = res_hi_q;
    assign result_lo_o = res_lo_q;
    assign alu_Op_o    = OP_ADD;
    assign alu_invA_o  = 1'b0;
    assign alu_sign_o  = 1'b0;

endmodule : alu_muldiv_seq
`default_nettype wire
